// File: rtl/t2t_pkg.sv
// Shared types and constants for the ITCH order decoder: event type
// encoding, the packed order event handed to the book builder, and the
// ITCH 5.0 message type codes and lengths.
// Optional feature macro: ITCH_DEC_TRADE_EN (decode 'P' trade messages).
package t2t_pkg;

  typedef enum logic [2:0] {
    EVT_ADD     = 3'd0,
    EVT_EXEC    = 3'd1,
    EVT_EXEC_PX = 3'd2,
    EVT_CANCEL  = 3'd3,
    EVT_DELETE  = 3'd4,
    EVT_REPLACE = 3'd5,
    EVT_TRADE   = 3'd6
  } evt_type_e;

  typedef struct packed {
    evt_type_e   evt_type;
    logic        stale;
    logic [15:0] stock_locate;
    logic [47:0] itch_ts;
    logic [63:0] order_ref;
    logic [63:0] new_order_ref;
    logic        side;
    logic [31:0] shares;
    logic [31:0] price;
    logic [31:0] seq;
    logic [39:0] ingress_ts;
  } order_evt_t;

  localparam int ORDER_EVT_W = 333;

  // Message type codes (byte 0 of the message)
  localparam logic [7:0] ITCH_TYPE_A = 8'h41;
  localparam logic [7:0] ITCH_TYPE_F = 8'h46;
  localparam logic [7:0] ITCH_TYPE_E = 8'h45;
  localparam logic [7:0] ITCH_TYPE_C = 8'h43;
  localparam logic [7:0] ITCH_TYPE_X = 8'h58;
  localparam logic [7:0] ITCH_TYPE_D = 8'h44;
  localparam logic [7:0] ITCH_TYPE_U = 8'h55;
  localparam logic [7:0] ITCH_TYPE_P = 8'h50;

  // Buy/sell indicator value that means "sell"
  localparam logic [7:0] ITCH_SIDE_SELL = 8'h53;

  // Exact message lengths in bytes
  localparam logic [7:0] ITCH_LEN_A = 8'd36;
  localparam logic [7:0] ITCH_LEN_F = 8'd40;
  localparam logic [7:0] ITCH_LEN_E = 8'd31;
  localparam logic [7:0] ITCH_LEN_C = 8'd36;
  localparam logic [7:0] ITCH_LEN_X = 8'd23;
  localparam logic [7:0] ITCH_LEN_D = 8'd19;
  localparam logic [7:0] ITCH_LEN_U = 8'd35;
  localparam logic [7:0] ITCH_LEN_P = 8'd44;

endpackage

// File: rtl/itch_order_decoder_if.sv
// Message-in / event-out bus of the ITCH order decoder. The slave modport
// is the decoder's view, the master modport is the surrounding fabric
// (message splitter upstream, book builder downstream).
interface itch_order_decoder_if #(
  parameter int MSG_BYTES = 64
);
  import t2t_pkg::*;

  logic [MSG_BYTES*8-1:0] s_axis_tdata;
  logic [7:0]             s_axis_tkeep;
  logic [95:0]            s_axis_tuser;
  logic                   s_axis_tvalid;
  logic                   s_axis_tready;

  order_evt_t             m_evt_data;
  logic                   m_evt_valid;
  logic                   m_evt_ready;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid,
    output s_axis_tready,
    output m_evt_data, m_evt_valid,
    input  m_evt_ready
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid,
    input  s_axis_tready,
    input  m_evt_data, m_evt_valid,
    output m_evt_ready
  );

endinterface

// File: rtl/itch_field_extract.sv
// Purely combinational decode of one ITCH message: recognises the
// order-affecting types, checks the exact length and pulls the big-endian
// fields into an order event.
// Optional feature macro: ITCH_DEC_TRADE_EN (adds 'P' -> EVT_TRADE).
module itch_field_extract
  import t2t_pkg::*;
#(
  parameter int MSG_BYTES = 64
) (
  input  logic [MSG_BYTES*8-1:0] tdata,
  input  logic [7:0]             tkeep,
  input  logic [95:0]            tuser,
  output logic                   is_order,
  output logic                   len_ok,
  output order_evt_t             evt
);

  logic [7:0] req_len;
  logic [7:0] msg_type;
  logic       unused_data;

  // Only some payload and sideband bits matter; fold the rest away
  assign unused_data = ^{tdata, tuser};
  assign msg_type    = tdata[7:0];

  // Assemble an n-byte big-endian field starting at byte offset off
  function automatic logic [63:0] be_field(input logic [MSG_BYTES*8-1:0] d,
                                           input int off, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) begin
      v = {v[55:0], d[(off+i)*8 +: 8]};
    end
    return v;
  endfunction

  // Type lookup, required length and per-type field placement
  always_comb begin
    evt      = '0;
    is_order = 1'b0;
    req_len  = '0;

    evt.stale        = tuser[47];
    evt.seq          = tuser[95:64];
    evt.ingress_ts   = tuser[39:0];
    evt.stock_locate = 16'(be_field(tdata, 1, 2));
    evt.itch_ts      = 48'(be_field(tdata, 5, 6));
    evt.order_ref    = be_field(tdata, 11, 8);

    case (msg_type)
      ITCH_TYPE_A, ITCH_TYPE_F: begin
        is_order     = 1'b1;
        req_len      = (msg_type == ITCH_TYPE_A) ? ITCH_LEN_A : ITCH_LEN_F;
        evt.evt_type = EVT_ADD;
        evt.side     = (tdata[19*8 +: 8] == ITCH_SIDE_SELL);
        evt.shares   = 32'(be_field(tdata, 20, 4));
        evt.price    = 32'(be_field(tdata, 32, 4));
      end
      ITCH_TYPE_E: begin
        is_order     = 1'b1;
        req_len      = ITCH_LEN_E;
        evt.evt_type = EVT_EXEC;
        evt.shares   = 32'(be_field(tdata, 19, 4));
      end
      ITCH_TYPE_C: begin
        is_order     = 1'b1;
        req_len      = ITCH_LEN_C;
        evt.evt_type = EVT_EXEC_PX;
        evt.shares   = 32'(be_field(tdata, 19, 4));
        evt.price    = 32'(be_field(tdata, 32, 4));
      end
      ITCH_TYPE_X: begin
        is_order     = 1'b1;
        req_len      = ITCH_LEN_X;
        evt.evt_type = EVT_CANCEL;
        evt.shares   = 32'(be_field(tdata, 19, 4));
      end
      ITCH_TYPE_D: begin
        is_order     = 1'b1;
        req_len      = ITCH_LEN_D;
        evt.evt_type = EVT_DELETE;
      end
      ITCH_TYPE_U: begin
        is_order          = 1'b1;
        req_len           = ITCH_LEN_U;
        evt.evt_type      = EVT_REPLACE;
        evt.new_order_ref = be_field(tdata, 19, 8);
        evt.shares        = 32'(be_field(tdata, 27, 4));
        evt.price         = 32'(be_field(tdata, 31, 4));
      end
`ifdef ITCH_DEC_TRADE_EN
      ITCH_TYPE_P: begin
        is_order          = 1'b1;
        req_len           = ITCH_LEN_P;
        evt.evt_type      = EVT_TRADE;
        evt.side          = (tdata[19*8 +: 8] == ITCH_SIDE_SELL);
        evt.shares        = 32'(be_field(tdata, 20, 4));
        evt.price         = 32'(be_field(tdata, 32, 4));
        evt.new_order_ref = be_field(tdata, 36, 8);
      end
`endif
      default: begin
        is_order = 1'b0;
      end
    endcase

    len_ok = is_order && (tkeep == req_len);
  end

endmodule

// File: rtl/itch_order_decoder.sv
// ITCH order decoder: two-stage valid/ready pipeline. Stage 1 holds the
// raw message; stage 2 holds the decoded order event. Non-order types,
// wrong lengths and out-of-range stock_locate values are dropped in the
// decode step and counted without ever occupying stage 2.
// Optional feature macro: ITCH_DEC_TRADE_EN (decode 'P' trade messages).
module itch_order_decoder
  import t2t_pkg::*;
#(
  parameter int MSG_BYTES = 64,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  itch_order_decoder_if.slave  bus,
  input  logic                 cfg_locate_en,
  input  logic [15:0]          cfg_locate_lo,
  input  logic [15:0]          cfg_locate_hi,
  output logic [CNT_WIDTH-1:0] stat_events,
  output logic [CNT_WIDTH-1:0] stat_filtered,
  output logic [CNT_WIDTH-1:0] stat_len_err
);

  logic                   out_of_reset;
  logic                   s1_valid;
  logic [MSG_BYTES*8-1:0] s1_data;
  logic [7:0]             s1_keep;
  logic [95:0]            s1_user;
  logic                   s2_valid;
  order_evt_t             s2_evt;

  logic                   in_acc;
  logic                   s1_adv;
  logic                   s1_fire;
  logic                   dec_is_order;
  logic                   dec_len_ok;
  order_evt_t             dec_evt;
  logic                   locate_ok;
  logic                   evt_load;
  logic                   drop_filt;
  logic                   drop_len;
  logic                   evt_hs;

  itch_field_extract #(.MSG_BYTES(MSG_BYTES)) u_extract (
    .tdata    (s1_data),
    .tkeep    (s1_keep),
    .tuser    (s1_user),
    .is_order (dec_is_order),
    .len_ok   (dec_len_ok),
    .evt      (dec_evt)
  );

  // Handshake and classification; tready is held low until the first
  // edge after reset release
  always_comb begin
    s1_adv            = !s2_valid || bus.m_evt_ready;
    bus.s_axis_tready = out_of_reset && (!s1_valid || s1_adv);
    in_acc            = bus.s_axis_tvalid && bus.s_axis_tready;
    s1_fire           = s1_valid && s1_adv;
    locate_ok         = !cfg_locate_en ||
                        ((dec_evt.stock_locate >= cfg_locate_lo) &&
                         (dec_evt.stock_locate <= cfg_locate_hi));
    evt_load          = s1_fire && dec_is_order && dec_len_ok && locate_ok;
    drop_len          = s1_fire && dec_is_order && !dec_len_ok;
    drop_filt         = s1_fire && (!dec_is_order || (dec_len_ok && !locate_ok));
    evt_hs            = s2_valid && bus.m_evt_ready;
    bus.m_evt_valid   = s2_valid;
    bus.m_evt_data    = s2_evt;
  end

  // Reset-release flag and stage-1 occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_of_reset <= 1'b0;
      s1_valid     <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
      if (bus.s_axis_tready) begin
        s1_valid <= in_acc;
      end
    end
  end

  // Stage-1 raw beat capture; contents are meaningless while s1_valid is low
  always_ff @(posedge clk) begin
    if (in_acc) begin
      s1_data <= bus.s_axis_tdata;
      s1_keep <= bus.s_axis_tkeep;
      s1_user <= bus.s_axis_tuser;
    end
  end

  // Stage-2 decoded event; dropped messages leave it empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_evt   <= '0;
    end else begin
      if (s1_adv) begin
        s2_valid <= evt_load;
      end
      if (evt_load) begin
        s2_evt <= dec_evt;
      end
    end
  end

  // Statistics counters, each free-running and wrapping independently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_events   <= '0;
      stat_filtered <= '0;
      stat_len_err  <= '0;
    end else begin
      if (evt_hs)    stat_events   <= stat_events + 1'b1;
      if (drop_filt) stat_filtered <= stat_filtered + 1'b1;
      if (drop_len)  stat_len_err  <= stat_len_err + 1'b1;
    end
  end

endmodule

// File: tb/tb_itch_order_decoder.sv
// Bench for itch_order_decoder: directed table vectors, hand-written
// multi-cycle sequences and randomized traffic checked against a
// behavioural model of the message decode rules.
// Optional feature macro: ITCH_DEC_TRADE_EN (changes 'P' expectations).
module tb_itch_order_decoder;
  import t2t_pkg::*;

  localparam int MB = 64;
  localparam int CW = 32;

  typedef struct packed {
    logic [MB*8-1:0] data;
    logic [7:0]      keep;
    logic [95:0]     user;
  } msg_t;

  typedef struct {
    logic [7:0]  typ;
    int          keep;
    logic [7:0]  side_b;
    int          kind;
    logic [2:0]  ty;
    logic [31:0] sh;
    logic [31:0] px;
    logic        sd;
    logic [63:0] nr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_locate_en;
  logic [15:0] cfg_locate_lo, cfg_locate_hi;
  logic [CW-1:0] stat_events, stat_filtered, stat_len_err;

  always #5 clk = ~clk;

  itch_order_decoder_if #(.MSG_BYTES(MB)) bus ();

  itch_order_decoder #(.MSG_BYTES(MB), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .cfg_locate_en (cfg_locate_en),
    .cfg_locate_lo (cfg_locate_lo),
    .cfg_locate_hi (cfg_locate_hi),
    .stat_events   (stat_events),
    .stat_filtered (stat_filtered),
    .stat_len_err  (stat_len_err)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit rand_bp = 0;
  order_evt_t exp_q[$];
  int unsigned exp_ev = 0, exp_filt = 0, exp_len = 0;
  order_evt_t last_evt;
  int hs_cyc[$];
  logic [2:0] hs_type[$];
  logic [15:0] hs_loc[$];
  logic prev_stall = 1'b0;
  order_evt_t prev_data;

  task automatic checkOutput(input string name, input logic [332:0] act,
                             input logic [332:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [MB*8-1:0] put_be(input logic [MB*8-1:0] d, input int off,
                                             input int n, input logic [63:0] v);
    for (int i = 0; i < n; i++) d[(off+i)*8 +: 8] = v[(n-1-i)*8 +: 8];
    return d;
  endfunction

  function automatic logic [63:0] get_be(input logic [MB*8-1:0] d, input int off, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = (v << 8) | 64'(d[(off+i)*8 +: 8]);
    return v;
  endfunction

  // Message layout table: length, event type and byte offsets (-1 = absent)
  function automatic void spec_info(input logic [7:0] t, output int len, output logic [2:0] ty,
                                    output int sh, output int px, output int nr, output bit sd);
    len = 0; ty = 0; sh = -1; px = -1; nr = -1; sd = 0;
    case (t)
      "A": begin len = 36; ty = 0; sh = 20; px = 32; sd = 1; end
      "F": begin len = 40; ty = 0; sh = 20; px = 32; sd = 1; end
      "E": begin len = 31; ty = 1; sh = 19; end
      "C": begin len = 36; ty = 2; sh = 19; px = 32; end
      "X": begin len = 23; ty = 3; sh = 19; end
      "D": begin len = 19; ty = 4; end
      "U": begin len = 35; ty = 5; nr = 19; sh = 27; px = 31; end
`ifdef ITCH_DEC_TRADE_EN
      "P": begin len = 44; ty = 6; sh = 20; px = 32; nr = 36; sd = 1; end
`endif
      default: len = 0;
    endcase
  endfunction

  // kind: 0 = event, 1 = filtered, 2 = length error
  function automatic void model(input msg_t m, input logic en, input logic [15:0] lo,
                                input logic [15:0] hi, output int kind, output order_evt_t e);
    int len, sh, px, nr;
    bit sd;
    logic [2:0] ty;
    logic [15:0] loc;
    spec_info(m.data[7:0], len, ty, sh, px, nr, sd);
    loc = 16'(get_be(m.data, 1, 2));
    e = '0;
    e.evt_type     = evt_type_e'(ty);
    e.stale        = m.user[47];
    e.stock_locate = loc;
    e.itch_ts      = 48'(get_be(m.data, 5, 6));
    e.order_ref    = get_be(m.data, 11, 8);
    if (nr >= 0) e.new_order_ref = get_be(m.data, nr, 8);
    if (sd) e.side = (m.data[19*8 +: 8] == "S");
    if (sh >= 0) e.shares = 32'(get_be(m.data, sh, 4));
    if (px >= 0) e.price = 32'(get_be(m.data, px, 4));
    e.seq        = m.user[95:64];
    e.ingress_ts = m.user[39:0];
    if (len == 0) kind = 1;
    else if (int'(m.keep) != len) kind = 2;
    else if (en && (loc < lo || loc > hi)) kind = 1;
    else kind = 0;
  endfunction

  function automatic msg_t mk_pattern(input logic [7:0] typ, input int keep,
                                      input logic [15:0] loc, input logic [7:0] side_b);
    msg_t m;
    for (int i = 0; i < MB; i++) m.data[i*8 +: 8] = 8'(i);
    m.data[7:0] = typ;
    m.data = put_be(m.data, 1, 2, 64'(loc));
    if (side_b != 0) m.data[19*8 +: 8] = side_b;
    m.keep = 8'(keep);
    m.user = {32'h5EC0_0001, 8'h00, 8'h00, 8'h80, 40'h00_1122_3344};
    return m;
  endfunction

  // Monitor: model on input accept, scoreboard on event handshake, hold check
  always @(negedge clk) begin
    msg_t mm;
    int kind;
    order_evt_t e;
    cyc++;
    if (rst_n) begin
      if (prev_stall) begin
        checkOutput("hold_valid", bus.m_evt_valid, 1);
        checkOutput("hold_data", bus.m_evt_data, prev_data);
      end
      prev_stall = bus.m_evt_valid && !bus.m_evt_ready;
      prev_data  = bus.m_evt_data;
      if (bus.s_axis_tvalid && bus.s_axis_tready) begin
        mm.data = bus.s_axis_tdata;
        mm.keep = bus.s_axis_tkeep;
        mm.user = bus.s_axis_tuser;
        model(mm, cfg_locate_en, cfg_locate_lo, cfg_locate_hi, kind, e);
        if (kind == 0) begin exp_q.push_back(e); exp_ev++; end
        else if (kind == 1) exp_filt++;
        else exp_len++;
      end
      if (bus.m_evt_valid && bus.m_evt_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL evt_unexpected: got %0h expected no event", bus.m_evt_data);
        end else begin
          e = exp_q.pop_front();
          checkOutput("evt_data", bus.m_evt_data, e);
        end
        last_evt = bus.m_evt_data;
        hs_cyc.push_back(cyc);
        hs_type.push_back(bus.m_evt_data.evt_type);
        hs_loc.push_back(bus.m_evt_data.stock_locate);
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic applyStimulus(input msg_t m);
    int waited = 0;
    bus.s_axis_tdata  = m.data;
    bus.s_axis_tkeep  = m.keep;
    bus.s_axis_tuser  = m.user;
    bus.s_axis_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.s_axis_tready) break;
      waited++;
      if (waited > 200) begin
        total++;
        bad++;
        $display("[TB] FAIL send_timeout: tready got 0 expected 1 within 200 cycles");
        break;
      end
      @(posedge clk); #1;
      if (rand_bp) bus.m_evt_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    bus.s_axis_tvalid = 1'b0;
    if (rand_bp) bus.m_evt_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    bus.s_axis_tvalid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input string tag);
    int w = 0;
    bus.s_axis_tvalid = 1'b0;
    bus.m_evt_ready   = 1'b1;
    while ((exp_q.size() != 0 || bus.m_evt_valid) && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 200) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_drain: %0d events still pending, expected 0", tag, exp_q.size());
    end
    idle(3);
    checkOutput({tag, "_events"}, stat_events, exp_ev);
    checkOutput({tag, "_filtered"}, stat_filtered, exp_filt);
    checkOutput({tag, "_len_err"}, stat_len_err, exp_len);
  endtask

  vec_t vt[11];
  logic [7:0] rtypes[10];

  initial begin
    msg_t m;
    int e0, f0, l0, rl, sh, px, nr;
    bit sd;
    logic [2:0] ty;

    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tkeep  = '0;
    bus.s_axis_tuser  = '0;
    bus.m_evt_ready   = 1'b1;
    cfg_locate_en = 1'b0;
    cfg_locate_lo = 16'h0000;
    cfg_locate_hi = 16'hFFFF;

    vt[0]  = '{"A", 36, "S", 0, 3'd0, 32'h14151617, 32'h20212223, 1'b1, 64'h0};
    vt[1]  = '{"F", 40, 8'h00, 0, 3'd0, 32'h14151617, 32'h20212223, 1'b0, 64'h0};
    vt[2]  = '{"E", 31, 8'h00, 0, 3'd1, 32'h13141516, 32'h0, 1'b0, 64'h0};
    vt[3]  = '{"C", 36, 8'h00, 0, 3'd2, 32'h13141516, 32'h20212223, 1'b0, 64'h0};
    vt[4]  = '{"X", 23, 8'h00, 0, 3'd3, 32'h13141516, 32'h0, 1'b0, 64'h0};
    vt[5]  = '{"D", 19, 8'h00, 0, 3'd4, 32'h0, 32'h0, 1'b0, 64'h0};
    vt[6]  = '{"U", 35, 8'h00, 0, 3'd5, 32'h1B1C1D1E, 32'h1F202122, 1'b0, 64'h131415161718191A};
    vt[7]  = '{"D", 18, 8'h00, 2, 3'd0, 32'h0, 32'h0, 1'b0, 64'h0};
    vt[8]  = '{"S", 12, 8'h00, 1, 3'd0, 32'h0, 32'h0, 1'b0, 64'h0};
    vt[9]  = '{"A", 35, 8'h00, 2, 3'd0, 32'h0, 32'h0, 1'b0, 64'h0};
`ifdef ITCH_DEC_TRADE_EN
    vt[10] = '{"P", 44, "S", 0, 3'd6, 32'h14151617, 32'h20212223, 1'b1, 64'h2425262728292A2B};
`else
    vt[10] = '{"P", 44, "S", 1, 3'd0, 32'h0, 32'h0, 1'b0, 64'h0};
`endif
    rtypes = '{"A", "F", "E", "C", "X", "D", "U", "P", "S", "R"};

    // Reset state
    #12;
    checkOutput("rst_tready", bus.s_axis_tready, 0);
    checkOutput("rst_evt_valid", bus.m_evt_valid, 0);
    checkOutput("rst_evt_data", bus.m_evt_data, 0);
    checkOutput("rst_stat_events", stat_events, 0);
    checkOutput("rst_stat_filtered", stat_filtered, 0);
    checkOutput("rst_stat_len_err", stat_len_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("tready_after_release", bus.s_axis_tready, 1);

    // Single add order, two-cycle latency
    m.data = '0;
    m.data[7:0] = "A";
    m.data = put_be(m.data, 1, 2, 64'h0001);
    m.data = put_be(m.data, 5, 6, 64'h0000_1234_5678);
    m.data = put_be(m.data, 11, 8, 64'hAB);
    m.data[19*8 +: 8] = "B";
    m.data = put_be(m.data, 20, 4, 64'd100);
    m.data = put_be(m.data, 32, 4, 64'h0016_E360);
    m.keep = 8'd36;
    m.user = {32'h0000_0007, 8'h41, 8'd36, 8'h00, 40'h00_0000_BEEF};
    bus.s_axis_tdata = m.data;
    bus.s_axis_tkeep = m.keep;
    bus.s_axis_tuser = m.user;
    bus.s_axis_tvalid = 1'b1;
    @(negedge clk);
    checkOutput("A_tready", bus.s_axis_tready, 1);
    @(posedge clk); #1;
    bus.s_axis_tvalid = 1'b0;
    @(negedge clk);
    checkOutput("A_valid_cycle1", bus.m_evt_valid, 0);
    @(negedge clk);
    checkOutput("A_valid_cycle2", bus.m_evt_valid, 1);
    checkOutput("A_type", bus.m_evt_data.evt_type, EVT_ADD);
    checkOutput("A_side", bus.m_evt_data.side, 0);
    checkOutput("A_shares", bus.m_evt_data.shares, 100);
    checkOutput("A_price", bus.m_evt_data.price, 32'h0016_E360);
    checkOutput("A_ref", bus.m_evt_data.order_ref, 64'hAB);
    checkOutput("A_locate", bus.m_evt_data.stock_locate, 1);
    checkOutput("A_ts", bus.m_evt_data.itch_ts, 48'h0000_1234_5678);
    checkOutput("A_seq", bus.m_evt_data.seq, 7);
    checkOutput("A_ingress", bus.m_evt_data.ingress_ts, 40'hBEEF);
    checkOutput("A_stale", bus.m_evt_data.stale, 0);
    @(posedge clk); #1;
    drain("A");
    checkOutput("A_stat_events", stat_events, 1);

    // Table-driven single messages
    for (int i = 0; i < 11; i++) begin
      e0 = int'(exp_ev); f0 = int'(exp_filt); l0 = int'(exp_len);
      applyStimulus(mk_pattern(vt[i].typ, vt[i].keep, 16'(i + 3), vt[i].side_b));
      drain($sformatf("tbl%0d", i));
      checkOutput($sformatf("tbl%0d_ev_delta", i), stat_events, 32'(e0 + (vt[i].kind == 0)));
      checkOutput($sformatf("tbl%0d_filt_delta", i), stat_filtered, 32'(f0 + (vt[i].kind == 1)));
      checkOutput($sformatf("tbl%0d_len_delta", i), stat_len_err, 32'(l0 + (vt[i].kind == 2)));
      if (vt[i].kind == 0) begin
        checkOutput($sformatf("tbl%0d_type", i), last_evt.evt_type, vt[i].ty);
        checkOutput($sformatf("tbl%0d_shares", i), last_evt.shares, vt[i].sh);
        checkOutput($sformatf("tbl%0d_price", i), last_evt.price, vt[i].px);
        checkOutput($sformatf("tbl%0d_side", i), last_evt.side, vt[i].sd);
        checkOutput($sformatf("tbl%0d_newref", i), last_evt.new_order_ref, vt[i].nr);
        checkOutput($sformatf("tbl%0d_locate", i), last_evt.stock_locate, 16'(i + 3));
      end
    end

    // Back-to-back D, E, U on consecutive cycles
    hs_cyc.delete(); hs_type.delete(); hs_loc.delete();
    applyStimulus(mk_pattern("D", 19, 16'd50, 8'h00));
    applyStimulus(mk_pattern("E", 31, 16'd51, 8'h00));
    applyStimulus(mk_pattern("U", 35, 16'd52, 8'h00));
    drain("b2b");
    checkOutput("b2b_count", hs_cyc.size(), 3);
    if (hs_cyc.size() == 3) begin
      checkOutput("b2b_gap1", hs_cyc[1], hs_cyc[0] + 1);
      checkOutput("b2b_gap2", hs_cyc[2], hs_cyc[1] + 1);
      checkOutput("b2b_t0", hs_type[0], EVT_DELETE);
      checkOutput("b2b_t1", hs_type[1], EVT_EXEC);
      checkOutput("b2b_t2", hs_type[2], EVT_REPLACE);
    end

    // Backpressure: 4 messages offered while downstream stalls 5 cycles
    hs_cyc.delete(); hs_type.delete(); hs_loc.delete();
    bus.m_evt_ready = 1'b0;
    fork
      begin
        applyStimulus(mk_pattern("A", 36, 16'd101, 8'h00));
        applyStimulus(mk_pattern("F", 40, 16'd102, 8'h00));
        applyStimulus(mk_pattern("E", 31, 16'd103, 8'h00));
        applyStimulus(mk_pattern("C", 36, 16'd104, 8'h00));
      end
      begin
        repeat (5) @(posedge clk);
        #2;
        checkOutput("bp_tready_low", bus.s_axis_tready, 0);
        checkOutput("bp_valid_held", bus.m_evt_valid, 1);
        checkOutput("bp_held_locate", bus.m_evt_data.stock_locate, 101);
        bus.m_evt_ready = 1'b1;
      end
    join
    drain("bp");
    checkOutput("bp_count", hs_loc.size(), 4);
    if (hs_loc.size() == 4) begin
      for (int i = 0; i < 4; i++)
        checkOutput($sformatf("bp_order%0d", i), hs_loc[i], 16'(101 + i));
    end

    // Locate range filter, inclusive bounds
    cfg_locate_en = 1'b1; cfg_locate_lo = 16'd10; cfg_locate_hi = 16'd20;
    hs_loc.delete();
    e0 = int'(exp_ev); f0 = int'(exp_filt);
    applyStimulus(mk_pattern("X", 23, 16'd9, 8'h00));
    applyStimulus(mk_pattern("X", 23, 16'd10, 8'h00));
    applyStimulus(mk_pattern("X", 23, 16'd20, 8'h00));
    applyStimulus(mk_pattern("X", 23, 16'd21, 8'h00));
    drain("loc");
    checkOutput("loc_filt_delta", stat_filtered, 32'(f0 + 2));
    checkOutput("loc_ev_delta", stat_events, 32'(e0 + 2));
    checkOutput("loc_count", hs_loc.size(), 2);
    if (hs_loc.size() == 2) begin
      checkOutput("loc_first", hs_loc[0], 10);
      checkOutput("loc_second", hs_loc[1], 20);
    end
    // Inverted range filters every order message
    cfg_locate_lo = 16'd20; cfg_locate_hi = 16'd10;
    e0 = int'(exp_ev); f0 = int'(exp_filt);
    applyStimulus(mk_pattern("A", 36, 16'd15, 8'h00));
    drain("inv");
    checkOutput("inv_filt_delta", stat_filtered, 32'(f0 + 1));
    checkOutput("inv_ev_delta", stat_events, 32'(e0));

    // Randomized traffic with random backpressure, three filter settings
    for (int b = 0; b < 3; b++) begin
      cfg_locate_en = (b != 0);
      cfg_locate_lo = (b == 2) ? 16'd20 : 16'd8;
      cfg_locate_hi = (b == 2) ? 16'd10 : 16'd24;
      rand_bp = 1;
      for (int n = 0; n < 150; n++) begin
        for (int w = 0; w < MB / 4; w++) m.data[w*32 +: 32] = $urandom();
        m.data[7:0] = rtypes[$urandom_range(0, 9)];
        m.data = put_be(m.data, 1, 2, 64'($urandom_range(0, 31)));
        spec_info(m.data[7:0], rl, ty, sh, px, nr, sd);
        m.keep = (rl != 0 && $urandom_range(0, 4) != 0) ? 8'(rl) : 8'($urandom_range(1, 63));
        m.user = {$urandom(), $urandom(), $urandom()};
        applyStimulus(m);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
      rand_bp = 0;
      drain($sformatf("rand%0d", b));
    end
    cfg_locate_en = 1'b0;

    // Asynchronous reset with both stages full
    bus.m_evt_ready = 1'b0;
    applyStimulus(mk_pattern("D", 19, 16'd1, 8'h00));
    applyStimulus(mk_pattern("D", 19, 16'd2, 8'h00));
    checkOutput("full_valid", bus.m_evt_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_ev = 0; exp_filt = 0; exp_len = 0;
    checkOutput("arst_valid", bus.m_evt_valid, 0);
    checkOutput("arst_data", bus.m_evt_data, 0);
    checkOutput("arst_tready", bus.s_axis_tready, 0);
    checkOutput("arst_events", stat_events, 0);
    checkOutput("arst_filtered", stat_filtered, 0);
    checkOutput("arst_len_err", stat_len_err, 0);
    bus.m_evt_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(mk_pattern("A", 36, 16'd7, "S"));
    drain("post_rst");
    checkOutput("post_rst_events", stat_events, 1);
    checkOutput("post_rst_side", last_evt.side, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/itch_order_decoder.md
Name: itch_order_decoder

Overview:
- Sits directly downstream of the ITCH message splitter and consumes one complete ITCH 5.0 message per beat.
- Decodes order-book-affecting messages (A, F, E, C, X, D, U) into one fixed-format order event for the book builder.
- Drops non-order messages, messages of the wrong length and messages for stock_locate values outside the configured range, and counts each drop.
- Two-stage valid/ready pipeline; no bubbles under full throughput.

Parameters:
- MSG_BYTES, 64, width of the input message bus in bytes.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_tdata  in  MSG_BYTES*8  message; byte i at bits [i*8+:8]; byte 0 = message type
- s_axis_tkeep  in  8  message length in bytes (a count, not a mask)
- s_axis_tuser  in  96  {seq[95:64], msg_type[63:56], msg_len[55:48], flags[47:40] (bit47 = stale), ingress_ts[39:0]}
- s_axis_tvalid  in  1  message valid
- s_axis_tready  out  1  accept
- m_evt_data  out  ORDER_EVT_W  order_evt_t (packed struct, see Decomposition)
- m_evt_valid  out  1  event valid
- m_evt_ready  in  1  downstream accept
- cfg_locate_en  in  1  enable stock_locate range filter
- cfg_locate_lo  in  16  inclusive low bound of the locate range
- cfg_locate_hi  in  16  inclusive high bound of the locate range
- stat_events  out  CNT_WIDTH  events emitted
- stat_filtered  out  CNT_WIDTH  messages dropped by type or locate filter
- stat_len_err  out  CNT_WIDTH  messages dropped for a length mismatch

Behaviour:
- Reset values: every output, pipeline valid bit and counter is 0, so s_axis_tready=0 during reset and 1 on the first cycle after release. In-flight messages are discarded.
- Handshakes: a transfer occurs when valid && ready.
  - s_axis_tready = !s1_valid || s1_adv.
  - s1_adv = !s2_valid || m_evt_ready.
  - m_evt_valid = s2_valid.
  - m_evt_data is held stable while valid && !ready.
- Stage 1 registers the raw input beat on accept.
- Stage 2 decodes and classifies the stage-1 beat when it advances:
  - Field extraction is big-endian at fixed offsets:
    - stock_locate = bytes 1-2
    - itch_ts = bytes 5-10
    - order_ref = bytes 11-18
  - Per type:
    - A / F: side = byte19 ('S'→1, else 0); shares = 20-23; price = 32-35.
    - E: shares = 19-22; price = 0.
    - C: shares = 19-22; price = 32-35.
    - X: shares = 19-22; price = 0.
    - D: shares = 0; price = 0.
    - U: new_order_ref = 19-26; shares = 27-30; price = 31-34.
  - Any field not listed for a type is 0.
  - Required lengths: A=36, F=40, E=31, C=36, X=23, D=19, U=35.
- Classification priority is fixed, and exactly one outcome applies per message:
  1. Type not in the set → stat_filtered++, no event.
  2. s_axis_tkeep ≠ required length → stat_len_err++, no event.
  3. cfg_locate_en && (locate < lo || locate > hi) → stat_filtered++, no event.
  4. Otherwise → event loaded into stage 2.
- Dropped messages free stage 1 without occupying stage 2.
- stat_events increments on each m_evt handshake.
- Type is taken from tdata byte 0. tuser msg_type is ignored except for being copied into nothing.
- Event fields carry seq and ingress_ts from tuser unchanged, plus stale = tuser bit47.
- cfg_* inputs are sampled in the decode cycle. A change affects only later messages.
- If lo > hi with cfg_locate_en=1, every order message is filtered.
- Latency is 2 cycles from input accept to m_evt_valid with no backpressure. Sustained rate is 1 message per cycle.
- Counters wrap from 2^CNT_WIDTH-1 to 0. The three counters increment independently when their events coincide in one cycle.

Optional Feature:
- Macro: ITCH_DEC_TRADE_EN.
- Defined: 'P' (required length 44) decodes to EVT_TRADE.
  - Fields: order_ref = 11-18, side = byte19, shares = 20-23, price = 32-35, new_order_ref = match number 36-43.
  - The length check and locate filter apply.
- Undefined: 'P' is treated as a non-order type and counts in stat_filtered.

Decomposition:
- t2t_pkg holds:
  - evt_type_e (3 bits): EVT_ADD=0, EVT_EXEC=1, EVT_EXEC_PX=2, EVT_CANCEL=3, EVT_DELETE=4, EVT_REPLACE=5, EVT_TRADE=6.
  - order_evt_t, packed MSB→LSB: {evt_type 3, stale 1, stock_locate 16, itch_ts 48, order_ref 64, new_order_ref 64, side 1, shares 32, price 32, seq 32, ingress_ts 40}.
  - ORDER_EVT_W = 333.
  - ITCH message length constants.
- One sub-module, itch_field_extract: purely combinational type/length/field decode, instantiated in stage 2.

Test Plan:
- 'A', locate 0x0001, ts 0x000012345678, ref 0xAB, side 'B', shares 100, price 0x0016E360, tkeep 36 → 2 cycles later EVT_ADD, side 0, shares 100, price 0x0016E360, seq/ingress_ts copied; stat_events=1.
- Back-to-back D, E, U, each length-correct → three events in order on three consecutive cycles with field values correct.
- m_evt_ready=0 for 5 cycles while 4 messages are offered → the first two are held, s_axis_tready drops, m_evt_data is stable; after release all 4 emerge in order with no loss or duplicates.
- 'D' with tkeep 18 → no event, stat_len_err=1. 'S' system event with tkeep 12 → no event, stat_filtered=1.
- cfg_locate_en=1, lo=10, hi=20; 'X' messages with locate 9, 10, 20, 21 → events only for 10 and 20; stat_filtered=2.
- rst_n asserted with both stages full → outputs 0 immediately; after release a new 'A' decodes normally and counters restart from 0.
